// File: rtl/imem_pkg.sv
// rtl/imem_pkg.sv - shared types and parameter bounds for the instruction memory responder
package imem_pkg;

  localparam int LATENCY_MIN     = 1;
  localparam int LATENCY_MAX     = 4;
  localparam int OUTSTANDING_MIN = 1;

  typedef struct packed {
    logic        valid;
    logic        err;
    logic [31:0] data;
  } pipe_entry_t;

  function automatic int idx_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/imem_array.sv
// rtl/imem_array.sv - 1-read/1-write word storage with a registered read port
// Contents are intentionally not reset so a loaded program survives a responder reset.
module imem_array #(
  parameter int DEPTH = 1024,
  parameter int AW    = 10
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [31:0]   wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [31:0]   rdata
);

  logic [31:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/imem_responder.sv
// rtl/imem_responder.sv - instruction fetch responder: grant, outstanding count, fixed-latency return
// IMEM_RANGE_CHECK_EN: flag out-of-range reads with err and drop out-of-range loads; otherwise indices wrap.
module imem_responder
  import imem_pkg::*;
#(
  parameter int          MEM_DEPTH       = 1024,
  parameter logic [31:0] BASE_ADDR       = 32'h0,
  parameter int          LATENCY         = 1,
  parameter int          MAX_OUTSTANDING = 2
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        instr_req_i,
  input  logic [31:0] instr_addr_i,
  output logic        instr_gnt_o,
  output logic        instr_rvalid_o,
  output logic [31:0] instr_rdata_o,
  output logic        instr_err_o,
  input  logic        load_we_i,
  input  logic [31:0] load_addr_i,
  input  logic [31:0] load_wdata_i
);

  localparam int AW   = idx_width(MEM_DEPTH);
  localparam int LAT  = (LATENCY < LATENCY_MIN) ? LATENCY_MIN :
                        (LATENCY > LATENCY_MAX) ? LATENCY_MAX : LATENCY;
  localparam int MAXO = (MAX_OUTSTANDING < OUTSTANDING_MIN) ? OUTSTANDING_MIN : MAX_OUTSTANDING;
  localparam int CW   = $clog2(MAXO + 1);

  logic [31:0]   rd_off, ld_off;
  logic [AW-1:0] rd_idx, ld_idx;
  logic          rd_oor, ld_ok;
  logic [31:0]   arr_rdata;
  logic [CW-1:0] cnt_q;
  logic          v0_q, e0_q;
  pipe_entry_t   head, tail;

  assign rd_off = instr_addr_i - BASE_ADDR;
  assign ld_off = load_addr_i - BASE_ADDR;
  assign rd_idx = AW'((rd_off >> 2) % 32'(MEM_DEPTH));
  assign ld_idx = AW'((ld_off >> 2) % 32'(MEM_DEPTH));

`ifdef IMEM_RANGE_CHECK_EN
  assign rd_oor = (rd_off >= 32'(4 * MEM_DEPTH));
  assign ld_ok  = (ld_off <  32'(4 * MEM_DEPTH));
`else
  assign rd_oor = 1'b0;
  assign ld_ok  = 1'b1;
`endif

  // A retiring response frees its slot in the same cycle, keeping the stream gapless at the limit.
  assign instr_gnt_o = rstn & instr_req_i & ~load_we_i &
                       ((cnt_q < CW'(MAXO)) | instr_rvalid_o);

  imem_array #(
    .DEPTH (MEM_DEPTH),
    .AW    (AW)
  ) u_array (
    .clk   (clk),
    .we    (load_we_i & ld_ok),
    .waddr (ld_idx),
    .wdata (load_wdata_i),
    .re    (instr_gnt_o),
    .raddr (rd_idx),
    .rdata (arr_rdata)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt_q <= '0;
      v0_q  <= 1'b0;
      e0_q  <= 1'b0;
    end else begin
      v0_q <= instr_gnt_o;
      e0_q <= instr_gnt_o & rd_oor;
      case ({instr_gnt_o, instr_rvalid_o})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  // First stage pairs the registered array word with its request; data is zeroed unless valid and clean.
  assign head = {v0_q, e0_q, (v0_q & ~e0_q) ? arr_rdata : 32'h0};

  generate
    if (LAT == 1) begin : g_lat1
      assign tail = head;
    end else begin : g_latn
      pipe_entry_t dly_q [LAT-1];
      always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
          for (int k = 0; k < LAT - 1; k++) dly_q[k] <= '0;
        end else begin
          dly_q[0] <= head;
          for (int k = 1; k < LAT - 1; k++) dly_q[k] <= dly_q[k-1];
        end
      end
      assign tail = dly_q[LAT-2];
    end
  endgenerate

  assign instr_rvalid_o = tail.valid;
  assign instr_rdata_o  = tail.data;
  assign instr_err_o    = tail.err;

endmodule

// File: tb/tb_imem_responder.sv
// tb/tb_imem_responder.sv - randomized scoreboard bench for imem_responder
// Reference model: word array plus a queue of expected responses stamped with their due cycle.
module tb_imem_responder;

  localparam int          DEPTH = 64;
  localparam logic [31:0] BASE  = 32'h0;
  localparam int          LAT   = 2;
  localparam int          MAXO  = 2;
`ifdef IMEM_RANGE_CHECK_EN
  localparam bit RC = 1'b1;
`else
  localparam bit RC = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        instr_req_i = 1'b0;
  logic [31:0] instr_addr_i = '0;
  logic        instr_gnt_o;
  logic        instr_rvalid_o;
  logic [31:0] instr_rdata_o;
  logic        instr_err_o;
  logic        load_we_i = 1'b0;
  logic [31:0] load_addr_i = '0;
  logic [31:0] load_wdata_i = '0;

  imem_responder #(
    .MEM_DEPTH       (DEPTH),
    .BASE_ADDR       (BASE),
    .LATENCY         (LAT),
    .MAX_OUTSTANDING (MAXO)
  ) dut (
    .clk            (clk),
    .rstn           (rstn),
    .instr_req_i    (instr_req_i),
    .instr_addr_i   (instr_addr_i),
    .instr_gnt_o    (instr_gnt_o),
    .instr_rvalid_o (instr_rvalid_o),
    .instr_rdata_o  (instr_rdata_o),
    .instr_err_o    (instr_err_o),
    .load_we_i      (load_we_i),
    .load_addr_i    (load_addr_i),
    .load_wdata_i   (load_wdata_i)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          due;
    logic [31:0] data;
    logic        err;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] ref_mem [DEPTH];
  int          cyc = 0;
  int          checks = 0;
  int          failures = 0;
  logic        exp_gnt = 1'b0;
  exp_t        mon_e;
  logic        mon_rv;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  task automatic chk_b(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0b expected %0b at cycle %0d", name, act, exp, cyc);
    end
  endtask

  function automatic bit in_range(input logic [31:0] a);
    logic [31:0] off;
    off = a - BASE;
    return off < 32'(4 * DEPTH);
  endfunction

  function automatic int word_of(input logic [31:0] a);
    logic [31:0] off;
    off = a - BASE;
    return int'((off / 4) % DEPTH);
  endfunction

  // One clock of stimulus; the model decides the grant and queues what should come back.
  task automatic step(input logic rn, input logic req, input logic [31:0] a,
                      input logic we, input logic [31:0] la, input logic [31:0] wd,
                      output logic g);
    logic ret, oor;
    @(posedge clk);
    #1;
    rstn         = rn;
    instr_req_i  = req;
    instr_addr_i = a;
    load_we_i    = we;
    load_addr_i  = la;
    load_wdata_i = wd;
    if (!rn) exp_q.delete();
    ret = (exp_q.size() > 0) && (exp_q[0].due == cyc);
    g   = rn && req && !we && ((exp_q.size() < MAXO) || ret);
    exp_gnt = g;
    if (g) begin
      oor = RC && !in_range(a);
      exp_q.push_back('{due: cyc + LAT, data: oor ? 32'h0 : ref_mem[word_of(a)], err: oor});
    end
    if (we && !(RC && !in_range(la))) ref_mem[word_of(la)] = wd;
  endtask

  task automatic idle(input int n);
    logic g;
    for (int i = 0; i < n; i++) step(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0, g);
  endtask

  always @(negedge clk) begin
    if (!rstn) begin
      chk_b("reset_gnt", instr_gnt_o, 1'b0);
      chk_b("reset_rvalid", instr_rvalid_o, 1'b0);
      chk("reset_rdata", instr_rdata_o, 32'h0);
      chk_b("reset_err", instr_err_o, 1'b0);
    end else begin
      chk_b("gnt", instr_gnt_o, exp_gnt);
      mon_rv = (exp_q.size() > 0) && (exp_q[0].due == cyc);
      chk_b("rvalid", instr_rvalid_o, mon_rv);
      if (mon_rv) begin
        mon_e = exp_q.pop_front();
        chk("rdata", instr_rdata_o, mon_e.data);
        chk_b("err", instr_err_o, mon_e.err);
      end else begin
        chk("idle_rdata", instr_rdata_o, 32'h0);
        chk_b("idle_err", instr_err_o, 1'b0);
      end
    end
  end

  initial begin
    logic        g;
    int          k, tries;
    logic [31:0] a, la;

    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0, g);

    for (int i = 0; i < DEPTH; i++)
      step(1'b1, 1'b0, 32'h0, 1'b1, BASE + 32'(4 * i),
           (i == 3) ? 32'h00A00093 : $urandom, g);

    // single read of word 3
    step(1'b1, 1'b1, BASE + 32'h0C, 1'b0, 32'h0, 32'h0, g);
    idle(LAT + 1);

    // request held across three sequential addresses
    k = 0;
    tries = 0;
    while (k < 3 && tries < 20) begin
      step(1'b1, 1'b1, BASE + 32'(4 * k), 1'b0, 32'h0, 32'h0, g);
      if (g) k++;
      tries++;
    end
    chk("b2b_all_granted", 32'(k), 32'd3);
    idle(LAT + 1);

    // load collides with a read of the same word
    step(1'b1, 1'b1, BASE + 32'h10, 1'b1, BASE + 32'h10, 32'hDEADBEEF, g);
    step(1'b1, 1'b1, BASE + 32'h10, 1'b0, 32'h0, 32'h0, g);
    idle(LAT + 1);

    // reads just past the end and far past it
    step(1'b1, 1'b1, BASE + 32'(4 * DEPTH), 1'b0, 32'h0, 32'h0, g);
    step(1'b1, 1'b1, BASE + 32'h1000, 1'b0, 32'h0, 32'h0, g);
    idle(LAT + 1);

    // reset while a response is in flight, then refill to the limit
    step(1'b1, 1'b1, BASE + 32'h8, 1'b0, 32'h0, 32'h0, g);
    step(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0, g);
    step(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0, g);
    idle(LAT + 2);
    for (int i = 0; i < MAXO + 2; i++)
      step(1'b1, 1'b1, BASE + 32'(4 * i), 1'b0, 32'h0, 32'h0, g);
    idle(LAT + 1);

    for (int i = 0; i < 3000; i++) begin
      a  = 32'($urandom_range(0, 8 * DEPTH - 1));
      la = 32'($urandom_range(0, 8 * DEPTH - 1));
      step($urandom_range(0, 299) != 0,
           $urandom_range(0, 9) < 7, BASE + a,
           $urandom_range(0, 9) < 2, BASE + la, $urandom, g);
    end

    idle(LAT + 3);
    chk("drain_empty", 32'(exp_q.size()), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
